pipe_delay_line: RTL and testbench

Parametrised, enable-gated register pipeline that delays a WIDTH-bit data word plus a valid flag by DEPTH advance cycles. It generalises the team's single-bit D flip-flop into a multi-bit, multi-stage, stallable delay line with flush and an occupancy count. It sits between a producer and consumer that need fixed-latency alignment, for example matching a datapath to a slower control path.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_delay_line_if.sv | 28 ++
 rtl/dff_en_stage.sv | 34 +++
 rtl/pipe_delay_line.sv | 78 +++++++
 tb/tb_pipe_delay_line.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_delay_line slice: width math and the
// legality check for the generic delay-line parameters.
package pipe_pkg;

    // Ceiling log2 with clog2(1) = 0, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int power;
        result = 0;
        power  = 1;
        for (int i = 0; i < 31; i++) begin
            if (power < value) begin
                result = result + 1;
                power  = power * 2;
            end
        end
        return result;
    endfunction

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int width, input int depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/pipe_delay_line_if.sv
// Producer/consumer bundle for pipe_delay_line; count width tracks DEPTH.
interface pipe_delay_line_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = count_width(DEPTH);

    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic [CW-1:0]    count;

    modport master (
        output en, flush, in_valid, d,
        input  q, out_valid, count
    );

    modport slave (
        input  en, flush, in_valid, d,
        output q, out_valid, count
    );

endinterface

// File: rtl/dff_en_stage.sv
// One delay-line stage: enable-gated data register plus a valid bit that
// can be cleared independently of the data path.
module dff_en_stage #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Data shifts on en even when valid is being cleared, so q tracks the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RESET_VALUE;
            q_valid <= 1'b0;
        end else begin
            if (en) begin
                q <= d;
            end
            if (clr_valid) begin
                q_valid <= 1'b0;
            end else if (en) begin
                q_valid <= d_valid;
            end
        end
    end

endmodule

// File: rtl/pipe_delay_line.sv
// Stallable, flushable WIDTH x DEPTH delay line with a registered
// occupancy count maintained incrementally alongside the valid chain.
module pipe_delay_line
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    pipe_delay_line_if.slave  bus
);

    localparam int CW = count_width(DEPTH);

    if (!params_legal(WIDTH, DEPTH)) begin : g_param_err
        $error("pipe_delay_line: WIDTH and DEPTH must both be at least 1");
    end

    logic [WIDTH-1:0] data_s [DEPTH];
    logic             vld_s  [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d_s;
        logic             stage_v_s;

        if (i == 0) begin : g_head
            assign stage_d_s = bus.d;
            assign stage_v_s = bus.in_valid;
        end else begin : g_body
            assign stage_d_s = data_s[i-1];
            assign stage_v_s = vld_s[i-1];
        end

        dff_en_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (bus.en),
            .clr_valid (bus.flush),
            .d         (stage_d_s),
            .d_valid   (stage_v_s),
            .q         (data_s[i]),
            .q_valid   (vld_s[i])
        );
    end

    // Insert and drop in the same advance cancel, so count stays equal to popcount(vld).
    always_comb begin
        count_nxt_s = count_r;
        if (bus.flush) begin
            count_nxt_s = {CW{1'b0}};
        end else if (bus.en) begin
            count_nxt_s = count_r + CW'(bus.in_valid) - CW'(vld_s[DEPTH-1]);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign bus.q         = data_s[DEPTH-1];
    assign bus.out_valid = vld_s[DEPTH-1];
    assign bus.count     = count_r;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed bench for pipe_delay_line: a DEPTH=4 instance and a DEPTH=1
// instance share one clock and reset and are exercised in turn.
module tb_pipe_delay_line;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    pipe_delay_line_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
    pipe_delay_line_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

    pipe_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    pipe_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic en, input logic fl, input logic iv, input logic [7:0] d);
        bus4.en       = en;
        bus4.flush    = fl;
        bus4.in_valid = iv;
        bus4.d        = d;
    endtask

    task automatic drive1(input logic en, input logic fl, input logic iv, input logic [7:0] d);
        bus1.en       = en;
        bus1.flush    = fl;
        bus1.in_valid = iv;
        bus1.d        = d;
    endtask

    logic [7:0] stream_q   [9] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
    logic       stream_ov  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] stream_cnt [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        logic [3:0] hist;
        logic       iv;

        // Reset with active-looking inputs that must be ignored.
        rst = 1'b1;
        drive4(1'b1, 1'b0, 1'b1, 8'hFF);
        drive1(1'b1, 1'b0, 1'b1, 8'hFF);
        tick();
        tick();
        check_val("rst_q4",   bus4.q,         8'h00);
        check_val("rst_ov4",  bus4.out_valid, 1'b0);
        check_val("rst_cnt4", bus4.count,     3'd0);
        check_val("rst_q1",   bus1.q,         8'h00);
        check_val("rst_ov1",  bus1.out_valid, 1'b0);
        check_val("rst_cnt1", bus1.count,     1'd0);
        rst = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 8'h00);

        // Streaming 01..05, then drain.
        for (int k = 0; k < 9; k++) begin
            if (k < 5) drive4(1'b1, 1'b0, 1'b1, 8'(k + 1));
            else       drive4(1'b1, 1'b0, 1'b0, 8'h00);
            tick();
            check_val($sformatf("stream_q_%0d", k),   bus4.q,         stream_q[k]);
            check_val($sformatf("stream_ov_%0d", k),  bus4.out_valid, stream_ov[k]);
            check_val($sformatf("stream_cnt_%0d", k), bus4.count,     stream_cnt[k]);
        end

        // Stall: A5 loaded, three idle cycles with ignored inputs, then advance.
        drive4(1'b1, 1'b0, 1'b1, 8'hA5);
        tick();
        check_val("stall_load_cnt", bus4.count, 3'd1);
        for (int k = 0; k < 3; k++) begin
            drive4(1'b0, 1'b0, 1'b1, 8'h33);
            tick();
            check_val($sformatf("stall_cnt_%0d", k), bus4.count,     3'd1);
            check_val($sformatf("stall_ov_%0d", k),  bus4.out_valid, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 1'b0, 1'b0, 8'h00);
            tick();
            check_val($sformatf("stall_out_ov_%0d", k), bus4.out_valid, (k == 2) ? 1'b1 : 1'b0);
            check_val($sformatf("stall_out_q_%0d", k),  bus4.q,         (k == 2) ? 8'hA5 : 8'h00);
        end
        check_val("stall_drain_cnt", bus4.count, 3'd0);

        // Bubbles: in_valid alternates; out_valid is the same pattern 4 advances later.
        hist = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            iv = (k % 2 == 1);
            drive4(1'b1, 1'b0, iv, 8'(8'h40 + k));
            tick();
            hist = {hist[2:0], iv};
            check_val($sformatf("bub_ov_%0d", k),  bus4.out_valid, hist[3]);
            check_val($sformatf("bub_cnt_%0d", k), bus4.count,     32'($countones(hist)));
            if (hist[3]) check_val($sformatf("bub_q_%0d", k), bus4.q, 8'(8'h40 + k - 3));
        end

        // Fill with four valid entries, then flush together with an advance.
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 1'b0, 1'b1, 8'(8'h10 + k));
            tick();
        end
        check_val("fill_cnt", bus4.count, 3'd4);
        check_val("fill_q",   bus4.q,     8'h10);
        drive4(1'b1, 1'b1, 1'b1, 8'hEE);
        tick();
        check_val("flush_ov",  bus4.out_valid, 1'b0);
        check_val("flush_cnt", bus4.count,     3'd0);
        check_val("flush_q",   bus4.q,         8'h11);
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 1'b0, 1'b0, 8'h00);
            tick();
            check_val($sformatf("post_flush_ov_%0d", k),  bus4.out_valid, 1'b0);
            check_val($sformatf("post_flush_cnt_%0d", k), bus4.count,     3'd0);
        end

        // Mid-stream reset with three entries in flight.
        for (int k = 0; k < 3; k++) begin
            drive4(1'b1, 1'b0, 1'b1, 8'(8'h21 + k));
            tick();
        end
        check_val("pre_rst_cnt", bus4.count, 3'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_cnt", bus4.count,     3'd0);
        check_val("mid_rst_ov",  bus4.out_valid, 1'b0);
        check_val("mid_rst_q",   bus4.q,         8'h00);
        drive4(1'b1, 1'b0, 1'b1, 8'h31);
        tick();
        check_val("after_rst_cnt", bus4.count,     3'd1);
        check_val("after_rst_ov",  bus4.out_valid, 1'b0);
        drive4(1'b0, 1'b0, 1'b0, 8'h00);

        // DEPTH=1: single-cycle latency, count in {0,1}.
        for (int k = 0; k < 5; k++) begin
            drive1(1'b1, 1'b0, 1'b1, 8'(8'h51 + k));
            tick();
            check_val($sformatf("d1_q_%0d", k),   bus1.q,         8'(8'h51 + k));
            check_val($sformatf("d1_ov_%0d", k),  bus1.out_valid, 1'b1);
            check_val($sformatf("d1_cnt_%0d", k), bus1.count,     1'd1);
        end
        drive1(1'b0, 1'b0, 1'b1, 8'h99);
        tick();
        check_val("d1_hold_q",   bus1.q,     8'h55);
        check_val("d1_hold_cnt", bus1.count, 1'd1);
        drive1(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check_val("d1_drain_ov",  bus1.out_valid, 1'b0);
        check_val("d1_drain_cnt", bus1.count,     1'd0);
        drive1(1'b1, 1'b0, 1'b1, 8'h66);
        tick();
        drive1(1'b1, 1'b1, 1'b1, 8'h77);
        tick();
        check_val("d1_flush_q",   bus1.q,         8'h77);
        check_val("d1_flush_ov",  bus1.out_valid, 1'b0);
        check_val("d1_flush_cnt", bus1.count,     1'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
